inst_fetch_if: RTL and testbench
================================

# inst_fetch_if

Instruction-fetch front end of the CPU. It sits directly upstream of the AXI bridge's instruction sram-like port. It generates sequential PCs and issues single-word read requests on `inst_sram_*`, keeping at most one request outstanding. Each returned instruction is held in a one-entry buffer until decode accepts it. On a redirect (branch or exception) it discards any in-flight response and refetches from the new PC.

## Interface
Parameters:
- `RESET_PC`, default 32'h1c00_0000: first fetch address after reset.

Ports:
- `aclk` in 1: the single clock.
- `aresetn` in 1: reset, asynchronous, active-low.
- `flush_valid` in 1: redirect request, one-cycle pulse.
- `flush_pc` in 32: redirect target, word-aligned.
- `inst_sram_req` out 1: read request.
- `inst_sram_wr` out 1: constant 0.
- `inst_sram_size` out 2: constant 2'b10 (4 bytes).
- `inst_sram_addr` out 32: fetch address (current PC).
- `inst_sram_wstrb` out 4: constant 0.
- `inst_sram_wdata` out 32: constant 0.
- `inst_sram_addr_ok` in 1: request accepted.
- `inst_sram_data_ok` in 1: response valid.
- `inst_sram_rdata` in 32: response data.
- `if_valid` out 1: instruction available to decode.
- `if_pc` out 32: PC of `if_inst`.
- `if_inst` out 32: instruction word.
- `id_ready` in 1: decode accepts this cycle.

## Operation
- States: INIT, REQ, WAIT, HOLD, DISCARD.
- Reset (async, while `aresetn`=0):
  - state=INIT, pc=`RESET_PC`, inst_buf=0.
  - Outputs: `inst_sram_req`=0, `if_valid`=0, `if_pc`=`RESET_PC`, `if_inst`=0, constant outputs at their constants.
- INIT -> REQ unconditionally on the first clock edge after reset release.
- REQ:
  - `inst_sram_req`=1, `inst_sram_addr`=pc.
  - On `addr_ok` -> WAIT.
  - The request stays asserted until `addr_ok`.
- WAIT: on `data_ok`, capture `rdata` into inst_buf -> HOLD.
- HOLD:
  - `if_valid`=1.
  - When `if_valid && id_ready`: pc <= pc+4 (mod 2^32, wraps silently) -> REQ.
- DISCARD: on `data_ok`, drop `rdata` -> REQ.
- In-order response rule: exactly one `data_ok` is expected per accepted request. A `data_ok` seen in INIT, REQ or HOLD is a protocol error; the block ignores it.
- Redirect handling (`flush_valid`=1 has priority over every other transition):
  - INIT/REQ without `addr_ok`: pc <= flush_pc, next state REQ. `inst_sram_addr` shows the new PC from the next cycle.
  - REQ with `addr_ok` in the same cycle: pc <= flush_pc -> DISCARD.
  - WAIT without `data_ok`: pc <= flush_pc -> DISCARD.
  - WAIT with `data_ok` in the same cycle: data dropped, pc <= flush_pc -> REQ.
  - HOLD (even if `id_ready`=1): buffered instruction dropped and not delivered; pc <= flush_pc -> REQ.
  - DISCARD without `data_ok`: pc <= flush_pc, stay in DISCARD.
  - DISCARD with `data_ok`: pc <= flush_pc -> REQ.
- Outputs:
  - `if_pc` is always pc; it is meaningful only while `if_valid`=1.
  - `if_inst` = inst_buf.

## Timing
- `inst_sram_req` and `if_valid` are decoded from state only. Neither is combinationally dependent on `addr_ok`, `data_ok` or `id_ready`.
- Best-case loop (`addr_ok` in the first REQ cycle, `data_ok` one cycle later, `id_ready`=1):
  - REQ (cycle 0), WAIT (cycle 1), HOLD (cycle 2), REQ (cycle 3).
  - One instruction per 3 cycles.
- First `inst_sram_req` is asserted in the second cycle after reset release (one INIT cycle).
- Redirect to refetch: the new PC's request is asserted the cycle after the flush (from REQ/HOLD) or the cycle after the discarded `data_ok` (from WAIT/DISCARD).
- Reset asserted mid-transaction returns to INIT immediately. Any response arriving afterwards is the interconnect's responsibility, because the bridge is reset on the same `aresetn`.

## Structure
- Shared CPU package holds:
  - state encoding localparams (one-hot, 5 bits: INIT, REQ, WAIT, HOLD, DISCARD);
  - `RESET_PC` default value;
  - sram size constant `SIZE_WORD`=2'b10.
- No sub-module: one FSM plus pc and inst_buf registers.

## Test plan
- Reset release, `addr_ok`=1 immediately, `data_ok` the next cycle with rdata=32'h0280_0400, `id_ready`=1 -> `inst_sram_req` rises in cycle 2 with addr 32'h1c00_0000. `if_valid`=1 with if_inst=32'h0280_0400 and if_pc=32'h1c00_0000 for exactly one cycle, then the next request uses addr 32'h1c00_0004.
- `addr_ok` withheld 5 cycles -> `inst_sram_req` stays 1 with a stable address and nothing else moves.
- `id_ready`=0 for 4 cycles in HOLD -> `if_valid`, `if_pc` and `if_inst` stay stable; no new request is issued.
- `flush_valid` in WAIT with flush_pc=32'h1c00_0100, old `data_ok` arrives 3 cycles later with rdata=32'hDEAD_BEEF -> 32'hDEAD_BEEF is never presented on `if_inst`. The next request uses addr 32'h1c00_0100 and is asserted the cycle after the discarded `data_ok`.
- `flush_valid` in the same cycle as `data_ok` in WAIT, and separately in HOLD with `id_ready`=1 -> no `if_valid` for the old instruction; the next request goes to flush_pc.
- pc=32'hFFFF_FFFC is delivered and accepted -> the next request address is 32'h0000_0000.
- `aresetn` pulsed low while in WAIT -> `inst_sram_req`=0 and `if_valid`=0 immediately (asynchronously); the fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/inst_fetch_if_pkg.sv
// Shared fetch definitions: state encoding,
// reset PC default and sram size code.
package inst_fetch_if_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h1c00_0000;
  localparam logic [1:0]  SIZE_WORD    = 2'b10;

  localparam int ST_INIT = 0;
  localparam int ST_REQ  = 1;
  localparam int ST_WAIT = 2;
  localparam int ST_HOLD = 3;
  localparam int ST_DISC = 4;

  typedef enum logic [4:0] {
    S_INIT = 5'b00001,
    S_REQ  = 5'b00010,
    S_WAIT = 5'b00100,
    S_HOLD = 5'b01000,
    S_DISC = 5'b10000
  } fetch_state_e;

  function automatic logic [31:0] seq_pc(
    input logic [31:0] pc
  );
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction fetch front end: one outstanding sram read, one-entry
// buffer to decode, redirect with stale-response discard.
// Ports: aclk/aresetn, flush_*, inst_sram_* master, if_* to decode, id_ready.
module inst_fetch_if
  import inst_fetch_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        flush_valid,
  input  logic [31:0] flush_pc,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [31:0] inst_sram_addr,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  input  logic        id_ready
);

  fetch_state_e state, state_nxt;
  logic [31:0]  pc, pc_nxt;
  logic [31:0]  inst_buf;
  logic         buf_we;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= S_INIT;
      pc       <= RESET_PC;
      inst_buf <= 32'd0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (buf_we) inst_buf <= inst_sram_rdata;
    end
  end

  // A flush always retargets pc; whether we must still
  // swallow a response decides between REQ and DISC.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    buf_we    = 1'b0;
    unique case (1'b1)
      state[ST_INIT]: begin
        state_nxt = S_REQ;
        if (flush_valid) pc_nxt = flush_pc;
      end
      state[ST_REQ]: begin
        if (flush_valid) begin
          pc_nxt    = flush_pc;
          state_nxt = inst_sram_addr_ok ? S_DISC : S_REQ;
        end else if (inst_sram_addr_ok) begin
          state_nxt = S_WAIT;
        end
      end
      state[ST_WAIT]: begin
        if (flush_valid) begin
          pc_nxt    = flush_pc;
          state_nxt = inst_sram_data_ok ? S_REQ : S_DISC;
        end else if (inst_sram_data_ok) begin
          buf_we    = 1'b1;
          state_nxt = S_HOLD;
        end
      end
      state[ST_HOLD]: begin
        if (flush_valid) begin
          pc_nxt    = flush_pc;
          state_nxt = S_REQ;
        end else if (id_ready) begin
          pc_nxt    = seq_pc(pc);
          state_nxt = S_REQ;
        end
      end
      state[ST_DISC]: begin
        if (flush_valid) pc_nxt = flush_pc;
        if (inst_sram_data_ok) state_nxt = S_REQ;
      end
      default: begin
        state_nxt = S_INIT;
      end
    endcase
  end

  assign inst_sram_req   = state[ST_REQ];
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = SIZE_WORD;
  assign inst_sram_addr  = pc;
  assign inst_sram_wstrb = 4'd0;
  assign inst_sram_wdata = 32'd0;

  assign if_valid = state[ST_HOLD];
  assign if_pc    = pc;
  assign if_inst  = inst_buf;

endmodule

// File: tb/tb_inst_fetch_if.sv
// Directed bench for inst_fetch_if with a transaction-level
// reference model checked every cycle.
module tb_inst_fetch_if;

  localparam logic [31:0] RPC = 32'h1c00_0000;

  logic        aclk;
  logic        aresetn;
  logic        flush_valid;
  logic [31:0] flush_pc;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        id_ready;

  int cmp  = 0;
  int mism = 0;
  bit dead_seen = 0;

  inst_fetch_if #(.RESET_PC(RPC)) dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .flush_valid       (flush_valid),
    .flush_pc          (flush_pc),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_wstrb   (inst_sram_wstrb),
    .inst_sram_wdata   (inst_sram_wdata),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .if_valid          (if_valid),
    .if_pc             (if_pc),
    .if_inst           (if_inst),
    .id_ready          (id_ready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      mism++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference model: counts requests and responses.
  bit          m_boot;
  bit          m_req;
  bit          m_pend;
  int          m_stale;
  bit          m_have;
  logic [31:0] m_pc;
  logic [31:0] m_buf;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_boot  = 0;
      m_req   = 0;
      m_pend  = 0;
      m_stale = 0;
      m_have  = 0;
      m_pc    = RPC;
      m_buf   = 32'd0;
    end else if (!m_boot) begin
      m_boot = 1;
      m_req  = 1;
      if (flush_valid) m_pc = flush_pc;
    end else begin
      bit acc, rsp, had;
      acc = m_req && inst_sram_addr_ok;
      rsp = inst_sram_data_ok && (m_pend || m_stale > 0);
      had = m_have;
      if (flush_valid) begin
        if (rsp) begin
          if (m_pend) m_pend = 0;
          else m_stale--;
        end
        if (m_pend) begin
          m_pend = 0;
          m_stale++;
        end
        if (acc) m_stale++;
        m_have = 0;
        m_pc   = flush_pc;
        m_req  = (m_stale == 0);
      end else begin
        if (rsp) begin
          if (m_pend) begin
            m_pend = 0;
            m_buf  = inst_sram_rdata;
            m_have = 1;
          end else begin
            m_stale--;
            if (m_stale == 0) m_req = 1;
          end
        end
        if (acc) begin
          m_req  = 0;
          m_pend = 1;
        end
        if (had && id_ready) begin
          m_have = 0;
          m_pc   = m_pc + 32'd4;
          m_req  = 1;
        end
      end
    end
  end

  always @(negedge aclk) begin
    chk("wr", {31'd0, inst_sram_wr}, 32'd0);
    chk("size", {30'd0, inst_sram_size}, 32'd2);
    chk("wstrb", {28'd0, inst_sram_wstrb}, 32'd0);
    chk("wdata", inst_sram_wdata, 32'd0);
    if (!aresetn) begin
      chk("rst_req", {31'd0, inst_sram_req}, 32'd0);
      chk("rst_valid", {31'd0, if_valid}, 32'd0);
      chk("rst_pc", if_pc, RPC);
      chk("rst_inst", if_inst, 32'd0);
    end else begin
      chk("req", {31'd0, inst_sram_req}, {31'd0, m_req});
      if (m_req) chk("addr", inst_sram_addr, m_pc);
      chk("valid", {31'd0, if_valid}, {31'd0, m_have});
      if (m_have) begin
        chk("if_pc", if_pc, m_pc);
        chk("if_inst", if_inst, m_buf);
      end
      if (if_valid && if_inst == 32'hDEAD_BEEF) dead_seen = 1;
    end
  end

  // One clock of stimulus; inputs change 1 after posedge.
  task automatic cyc(input bit ao, input bit dk,
                     input logic [31:0] rd, input bit ir,
                     input bit fv, input logic [31:0] fp);
    inst_sram_addr_ok = ao;
    inst_sram_data_ok = dk;
    inst_sram_rdata   = rd;
    id_ready          = ir;
    flush_valid       = fv;
    flush_pc          = fp;
    @(posedge aclk);
    #1;
    inst_sram_addr_ok = 0;
    inst_sram_data_ok = 0;
    inst_sram_rdata   = 32'd0;
    id_ready          = 0;
    flush_valid       = 0;
    flush_pc          = 32'd0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    aresetn           = 0;
    flush_valid       = 0;
    flush_pc          = 0;
    inst_sram_addr_ok = 0;
    inst_sram_data_ok = 0;
    inst_sram_rdata   = 0;
    id_ready          = 0;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1;
    chk("init_req", {31'd0, inst_sram_req}, 32'd0);
    idle(1);
    chk("first_req", {31'd0, inst_sram_req}, 32'd1);
    chk("first_addr", inst_sram_addr, 32'h1c00_0000);
    cyc(1, 0, 0, 1, 0, 0);
    chk("wait_req", {31'd0, inst_sram_req}, 32'd0);
    cyc(0, 1, 32'h0280_0400, 1, 0, 0);
    chk("hold_valid", {31'd0, if_valid}, 32'd1);
    chk("hold_inst", if_inst, 32'h0280_0400);
    chk("hold_pc", if_pc, 32'h1c00_0000);
    cyc(0, 0, 0, 1, 0, 0);
    chk("one_valid", {31'd0, if_valid}, 32'd0);
    chk("next_addr", inst_sram_addr, 32'h1c00_0004);

    idle(5);
    chk("stall_req", {31'd0, inst_sram_req}, 32'd1);
    chk("stall_addr", inst_sram_addr, 32'h1c00_0004);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h1111_0001, 0, 0, 0);
    idle(4);
    chk("bp_inst", if_inst, 32'h1111_0001);
    chk("bp_req", {31'd0, inst_sram_req}, 32'd0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("bp_addr", inst_sram_addr, 32'h1c00_0008);

    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h1c00_0100);
    idle(2);
    cyc(0, 1, 32'hDEAD_BEEF, 1, 0, 0);
    chk("disc_req", {31'd0, inst_sram_req}, 32'd1);
    chk("disc_addr", inst_sram_addr, 32'h1c00_0100);

    cyc(0, 1, 32'h4444_4444, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h1111_1111, 1, 1, 32'h1c00_0200);
    chk("fdk_valid", {31'd0, if_valid}, 32'd0);
    chk("fdk_addr", inst_sram_addr, 32'h1c00_0200);

    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h2222_2222, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 32'hFFFF_FFFC);
    chk("fh_valid", {31'd0, if_valid}, 32'd0);
    chk("fh_addr", inst_sram_addr, 32'hFFFF_FFFC);

    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h3333_3333, 0, 0, 0);
    chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 1, 0, 0);
    chk("wrap_addr", inst_sram_addr, 32'h0000_0000);

    cyc(1, 0, 0, 0, 1, 32'h0000_0040);
    chk("racc_req", {31'd0, inst_sram_req}, 32'd0);
    cyc(0, 0, 0, 0, 1, 32'h0000_0080);
    cyc(0, 1, 32'h5555_5555, 0, 0, 0);
    chk("dd_addr", inst_sram_addr, 32'h0000_0080);

    cyc(1, 0, 0, 0, 0, 0);
    #2;
    aresetn = 0;
    #1;
    chk("arst_req", {31'd0, inst_sram_req}, 32'd0);
    chk("arst_valid", {31'd0, if_valid}, 32'd0);
    chk("arst_pc", if_pc, RPC);
    @(posedge aclk);
    #1;
    aresetn = 1;
    idle(1);
    chk("rst_addr", inst_sram_addr, RPC);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h6666_6666, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    idle(2);

    cmp++;
    if (dead_seen) begin
      mism++;
      $display("FAIL dead_beef: got presented want never");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmp, mism);
    $finish;
  end

endmodule
